// File: rtl/dsp_fmgr_ctrl_module.sv
// dsp_fmgr_ctrl_module: allocation controller between the four dispatch slots
// and the reservation-station free-list manager. Grants the largest in-order
// request prefix the credit counter allows, buffers entry releases from two
// issue pipes in a return FIFO, drains it into the free list, and sequences
// trap-flush recovery.
module dsp_fmgr_ctrl_module #(
  parameter int RSV_IDX_WIDTH  = 6,
  parameter int RSV_ENTRIES    = 64,
  parameter int RET_FIFO_DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_csr_trap_flush,
  input  logic                     i_dsp_stall,
  input  logic [3:0]               i_dsp_req_vld,
  output logic [3:0]               o_dsp_gnt,
  output logic [RSV_IDX_WIDTH-1:0] o_dsp_entry_0,
  output logic [RSV_IDX_WIDTH-1:0] o_dsp_entry_1,
  output logic [RSV_IDX_WIDTH-1:0] o_dsp_entry_2,
  output logic [RSV_IDX_WIDTH-1:0] o_dsp_entry_3,
  output logic                     o_dsp_busy,
  output logic                     o_fmgr_free_req_0,
  output logic                     o_fmgr_free_req_1,
  output logic                     o_fmgr_free_req_2,
  output logic                     o_fmgr_free_req_3,
  input  logic [RSV_IDX_WIDTH-1:0] i_fmgr_free_entry_0,
  input  logic [RSV_IDX_WIDTH-1:0] i_fmgr_free_entry_1,
  input  logic [RSV_IDX_WIDTH-1:0] i_fmgr_free_entry_2,
  input  logic [RSV_IDX_WIDTH-1:0] i_fmgr_free_entry_3,
  input  logic                     i_fmgr_list_empty,
  output logic                     o_fmgr_stall,
  output logic [3:0]               o_fmgr_ret_vld,
  output logic [RSV_IDX_WIDTH-1:0] o_fmgr_ret_entry_0,
  output logic [RSV_IDX_WIDTH-1:0] o_fmgr_ret_entry_1,
  output logic [RSV_IDX_WIDTH-1:0] o_fmgr_ret_entry_2,
  output logic [RSV_IDX_WIDTH-1:0] o_fmgr_ret_entry_3,
  input  logic [1:0]               i_rel_a_vld,
  input  logic [1:0]               i_rel_b_vld,
  input  logic [RSV_IDX_WIDTH-1:0] i_rel_a_entry_0,
  input  logic [RSV_IDX_WIDTH-1:0] i_rel_a_entry_1,
  input  logic [RSV_IDX_WIDTH-1:0] i_rel_b_entry_0,
  input  logic [RSV_IDX_WIDTH-1:0] i_rel_b_entry_1,
  output logic                     o_rel_rdy,
  output logic                     o_err
);

  localparam int PTR_W = $clog2(RET_FIFO_DEPTH);
  localparam int OCC_W = PTR_W + 1;

  typedef enum logic {ST_RUN, ST_FLUSH} state_e;

  state_e                   state_q, state_d;
  logic [6:0]               cnt_q, cnt_d;
  logic [PTR_W-1:0]         head_q, head_d;
  logic [PTR_W-1:0]         tail_q, tail_d;
  logic [OCC_W-1:0]         occ_q, occ_d;
  logic [RSV_IDX_WIDTH-1:0] fifo_q [RET_FIFO_DEPTH];
  logic [RSV_IDX_WIDTH-1:0] fifo_d [RET_FIFO_DEPTH];
  logic                     err_q, err_d;

  logic [2:0]               req_cnt;
  logic [2:0]               gnt_cnt;
  logic [2:0]               drain_cnt;
  logic [2:0]               enq_cnt;
  logic [3:0]               gnt;
  logic                     grant_block;
  logic                     drain_en;
  logic                     flushing;
  logic                     rel_rdy;
  logic [PTR_W-1:0]         wr_ptr;
  logic [3:0]               rel_vld;
  logic [RSV_IDX_WIDTH-1:0] rel_entry [4];
  logic [3:0]               ret_vld;
  logic [RSV_IDX_WIDTH-1:0] ret_entry [4];
  logic [RSV_IDX_WIDTH-1:0] free_entry [4];

  // Grant the in-order request prefix, capped by credit; any flush or stall blocks it.
  always_comb begin
    req_cnt = 3'(i_dsp_req_vld[0]) + 3'(i_dsp_req_vld[1])
            + 3'(i_dsp_req_vld[2]) + 3'(i_dsp_req_vld[3]);
    grant_block = (state_q == ST_FLUSH) | i_dsp_stall | i_csr_trap_flush;
    if ({4'b0000, req_cnt} <= cnt_q) gnt_cnt = req_cnt;
    else                             gnt_cnt = cnt_q[2:0];
    if (grant_block) gnt_cnt = 3'd0;
    gnt = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      if (3'(k) < gnt_cnt) gnt[k] = i_dsp_req_vld[k];
    end
  end

  // Drain up to four head entries when running, not stalled and not flushing.
  always_comb begin
    flushing = i_csr_trap_flush | (state_q == ST_FLUSH);
    drain_en = (state_q == ST_RUN) & ~i_dsp_stall & ~i_csr_trap_flush;
    if (!drain_en)                   drain_cnt = 3'd0;
    else if (occ_q >= OCC_W'(4))     drain_cnt = 3'd4;
    else                             drain_cnt = 3'(occ_q);
    for (int k = 0; k < 4; k++) begin
      ret_entry[k] = fifo_q[head_q + PTR_W'(k)];
      ret_vld[k]   = (3'(k) < drain_cnt);
    end
    rel_rdy = (state_q == ST_RUN) && ((OCC_W'(RET_FIFO_DEPTH) - occ_q) >= OCC_W'(4));
  end

  // Compact valid releases into the FIFO tail in a0, a1, b0, b1 order.
  always_comb begin
    rel_vld      = {i_rel_b_vld[1], i_rel_b_vld[0], i_rel_a_vld[1], i_rel_a_vld[0]};
    rel_entry[0] = i_rel_a_entry_0;
    rel_entry[1] = i_rel_a_entry_1;
    rel_entry[2] = i_rel_b_entry_0;
    rel_entry[3] = i_rel_b_entry_1;
    fifo_d       = fifo_q;
    wr_ptr       = tail_q;
    enq_cnt      = 3'd0;
    if (rel_rdy) begin
      for (int k = 0; k < 4; k++) begin
        if (rel_vld[k]) begin
          fifo_d[wr_ptr] = rel_entry[k];
          wr_ptr         = wr_ptr + PTR_W'(1);
          enq_cnt        = enq_cnt + 3'd1;
        end
      end
    end
  end

  // Next-state for FSM, credit, FIFO bookkeeping and the sticky error flag.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (i_csr_trap_flush)  state_d = ST_FLUSH;
      ST_FLUSH: if (!i_csr_trap_flush) state_d = ST_RUN;
      default:                         state_d = ST_RUN;
    endcase
    if (flushing) begin
      head_d = '0;
      tail_d = '0;
      occ_d  = '0;
      cnt_d  = 7'(RSV_ENTRIES);
    end else begin
      head_d = head_q + PTR_W'(drain_cnt);
      tail_d = wr_ptr;
      occ_d  = occ_q + OCC_W'(enq_cnt) - OCC_W'(drain_cnt);
      cnt_d  = cnt_q + 7'(drain_cnt) - 7'(gnt_cnt);
    end
    err_d = err_q | (i_fmgr_list_empty & (|gnt));
  end

  // Single register block for all controller state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      cnt_q   <= 7'(RSV_ENTRIES);
      head_q  <= '0;
      tail_q  <= '0;
      occ_q   <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < RET_FIFO_DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      occ_q   <= occ_d;
      err_q   <= err_d;
      fifo_q  <= fifo_d;
    end
  end

  // Output wiring; the free list is told to freeze only when a flush is not pending.
  always_comb begin
    free_entry[0]      = i_fmgr_free_entry_0;
    free_entry[1]      = i_fmgr_free_entry_1;
    free_entry[2]      = i_fmgr_free_entry_2;
    free_entry[3]      = i_fmgr_free_entry_3;
    o_dsp_gnt          = gnt;
    o_dsp_entry_0      = free_entry[0];
    o_dsp_entry_1      = free_entry[1];
    o_dsp_entry_2      = free_entry[2];
    o_dsp_entry_3      = free_entry[3];
    o_fmgr_free_req_0  = gnt[0];
    o_fmgr_free_req_1  = gnt[1];
    o_fmgr_free_req_2  = gnt[2];
    o_fmgr_free_req_3  = gnt[3];
    o_dsp_busy         = (state_q == ST_FLUSH);
    o_fmgr_stall       = i_dsp_stall & ~i_csr_trap_flush;
    o_fmgr_ret_vld     = ret_vld;
    o_fmgr_ret_entry_0 = ret_entry[0];
    o_fmgr_ret_entry_1 = ret_entry[1];
    o_fmgr_ret_entry_2 = ret_entry[2];
    o_fmgr_ret_entry_3 = ret_entry[3];
    o_rel_rdy          = rel_rdy;
    o_err              = err_q;
  end

endmodule

// File: tb/tb_dsp_fmgr_ctrl_module.sv
// tb_dsp_fmgr_ctrl_module: directed bench for the dispatch allocation
// controller with a queue-based behavioural model compared every cycle.
module tb_dsp_fmgr_ctrl_module;

   localparam int W = 6;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         flushIn = 1'b0;
   logic         stallIn = 1'b0;
   logic [3:0]   reqVld = 4'b0000;
   logic [3:0]   dspGnt;
   logic [W-1:0] dspEntry [4];
   logic         dspBusy;
   logic [3:0]   freeReq;
   logic [W-1:0] freeEntry [4];
   logic         listEmpty = 1'b0;
   logic         fmgrStall;
   logic [3:0]   retVld;
   logic [W-1:0] retEntry [4];
   logic [1:0]   relAVld = 2'b00;
   logic [1:0]   relBVld = 2'b00;
   logic [W-1:0] relEntry [4];
   logic         relRdy;
   logic         errOut;

   int checks = 0;
   int fails  = 0;

   // Behavioural model state: credit as a plain integer, FIFO as a queue.
   int   mCredit;
   int   mQ[$];
   bit   mFlush;
   bit   mErr;
   int   expN;
   int   expD;
   bit   expRdy;
   int   nReq;
   bit   blocked;
   logic [3:0] expGnt;
   logic [3:0] expRet;

   always #5 clk = ~clk;

   dsp_fmgr_ctrl_module dut (
      .clk(clk), .rst(rst),
      .i_csr_trap_flush(flushIn), .i_dsp_stall(stallIn),
      .i_dsp_req_vld(reqVld), .o_dsp_gnt(dspGnt),
      .o_dsp_entry_0(dspEntry[0]), .o_dsp_entry_1(dspEntry[1]),
      .o_dsp_entry_2(dspEntry[2]), .o_dsp_entry_3(dspEntry[3]),
      .o_dsp_busy(dspBusy),
      .o_fmgr_free_req_0(freeReq[0]), .o_fmgr_free_req_1(freeReq[1]),
      .o_fmgr_free_req_2(freeReq[2]), .o_fmgr_free_req_3(freeReq[3]),
      .i_fmgr_free_entry_0(freeEntry[0]), .i_fmgr_free_entry_1(freeEntry[1]),
      .i_fmgr_free_entry_2(freeEntry[2]), .i_fmgr_free_entry_3(freeEntry[3]),
      .i_fmgr_list_empty(listEmpty), .o_fmgr_stall(fmgrStall),
      .o_fmgr_ret_vld(retVld),
      .o_fmgr_ret_entry_0(retEntry[0]), .o_fmgr_ret_entry_1(retEntry[1]),
      .o_fmgr_ret_entry_2(retEntry[2]), .o_fmgr_ret_entry_3(retEntry[3]),
      .i_rel_a_vld(relAVld), .i_rel_b_vld(relBVld),
      .i_rel_a_entry_0(relEntry[0]), .i_rel_a_entry_1(relEntry[1]),
      .i_rel_b_entry_0(relEntry[2]), .i_rel_b_entry_1(relEntry[3]),
      .o_rel_rdy(relRdy), .o_err(errOut)
   );

   // One comparison: count it, and report a FAIL line on mismatch.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Advance to just after the next rising edge, drive a new input vector,
   // then wait for the falling edge where outputs are sampled.
   task automatic applyStimulus(input logic [3:0] req, input logic stall, input logic flush,
                                input logic [1:0] aV, input logic [1:0] bV,
                                input logic [W-1:0] base, input logic empty);
      @(posedge clk);
      #1;
      reqVld      = req;
      stallIn     = stall;
      flushIn     = flush;
      relAVld     = aV;
      relBVld     = bV;
      relEntry[0] = base;
      relEntry[1] = base + 6'd1;
      relEntry[2] = base + 6'd2;
      relEntry[3] = base + 6'd3;
      listEmpty   = empty;
      for (int k = 0; k < 4; k++) freeEntry[k] = W'($urandom_range(0, 63));
      @(negedge clk);
   endtask

   // Model prediction and full output comparison on every falling edge out of reset.
   always @(negedge clk) begin
      if (!rst) begin
         nReq    = int'(reqVld[0]) + int'(reqVld[1]) + int'(reqVld[2]) + int'(reqVld[3]);
         blocked = mFlush || stallIn || flushIn;
         expN    = blocked ? 0 : ((nReq < mCredit) ? nReq : mCredit);
         expGnt  = 4'((1 << expN) - 1);
         expD    = (!mFlush && !stallIn && !flushIn) ? ((mQ.size() < 4) ? mQ.size() : 4) : 0;
         expRet  = 4'((1 << expD) - 1);
         expRdy  = !mFlush && ((8 - mQ.size()) >= 4);
         checkOutput("model_gnt", dspGnt, expGnt);
         checkOutput("model_free_req", freeReq, expGnt);
         checkOutput("model_busy", dspBusy, mFlush);
         checkOutput("model_rel_rdy", relRdy, expRdy);
         checkOutput("model_fmgr_stall", fmgrStall, stallIn & ~flushIn);
         checkOutput("model_ret_vld", retVld, expRet);
         checkOutput("model_err", errOut, mErr);
         for (int k = 0; k < 4; k++) begin
            if (k < expN) checkOutput("model_dsp_entry", dspEntry[k], freeEntry[k]);
            if (k < expD) checkOutput("model_ret_entry", retEntry[k], mQ[k]);
         end
      end
   end

   // Model state update on the rising edge using the prediction just made.
   always @(posedge clk) begin
      if (rst) begin
         mCredit = 64;
         mQ.delete();
         mFlush  = 1'b0;
         mErr    = 1'b0;
      end else begin
         if (expN > 0 && listEmpty) mErr = 1'b1;
         if (mFlush || flushIn) begin
            mQ.delete();
            mCredit = 64;
         end else begin
            for (int k = 0; k < expD; k++) void'(mQ.pop_front());
            mCredit = mCredit + expD - expN;
            if (expRdy) begin
               if (relAVld[0]) mQ.push_back(int'(relEntry[0]));
               if (relAVld[1]) mQ.push_back(int'(relEntry[1]));
               if (relBVld[0]) mQ.push_back(int'(relEntry[2]));
               if (relBVld[1]) mQ.push_back(int'(relEntry[3]));
            end
         end
         mFlush = flushIn;
      end
   end

   // Directed scenario with hand-computed literal expectations.
   initial begin
      for (int k = 0; k < 4; k++) begin
         freeEntry[k] = '0;
         relEntry[k]  = '0;
      end
      stallIn = 1'b1;
      @(negedge clk);
      checkOutput("reset_fmgr_stall", fmgrStall, 1);
      checkOutput("reset_gnt", dspGnt, 0);
      checkOutput("reset_rel_rdy", relRdy, 1);
      @(posedge clk);
      #1;
      stallIn = 1'b0;
      rst     = 1'b0;
      @(negedge clk);
      checkOutput("reset_busy", dspBusy, 0);
      checkOutput("reset_ret_vld", retVld, 0);
      checkOutput("reset_err", errOut, 0);

      // Full-width requests drain the 64 credits in 16 cycles.
      for (int i = 0; i < 16; i++) begin
         applyStimulus(4'b1111, 0, 0, 2'b00, 2'b00, 6'd0, 0);
         checkOutput("full_gnt", dspGnt, 4'b1111);
      end
      applyStimulus(4'b1111, 0, 0, 2'b00, 2'b00, 6'd0, 0);
      checkOutput("credit_out_gnt", dspGnt, 4'b0000);
      checkOutput("credit_out_err", errOut, 0);

      // Two releases return two credits, then a three-wide request gets two.
      applyStimulus(4'b0000, 0, 0, 2'b11, 2'b00, 6'd40, 0);
      checkOutput("no_bypass_ret_vld", retVld, 4'b0000);
      applyStimulus(4'b0000, 0, 0, 2'b00, 2'b00, 6'd0, 0);
      checkOutput("drain2_ret_vld", retVld, 4'b0011);
      checkOutput("drain2_entry0", retEntry[0], 40);
      checkOutput("drain2_entry1", retEntry[1], 41);
      applyStimulus(4'b0111, 0, 0, 2'b00, 2'b00, 6'd0, 0);
      checkOutput("cnt2_gnt", dspGnt, 4'b0011);
      checkOutput("cnt2_free_req2", freeReq[2], 0);
      applyStimulus(4'b0111, 0, 0, 2'b00, 2'b00, 6'd0, 0);
      checkOutput("cnt0_gnt", dspGnt, 4'b0000);

      // Grant three while draining two with three credits.
      applyStimulus(4'b0000, 0, 0, 2'b11, 2'b01, 6'd50, 0);
      applyStimulus(4'b0000, 0, 0, 2'b11, 2'b00, 6'd60, 0);
      checkOutput("drain3_ret_vld", retVld, 4'b0111);
      checkOutput("drain3_entry2", retEntry[2], 52);
      applyStimulus(4'b0111, 0, 0, 2'b00, 2'b00, 6'd0, 0);
      checkOutput("mix_gnt", dspGnt, 4'b0111);
      checkOutput("mix_ret_vld", retVld, 4'b0011);
      checkOutput("mix_entry0", retEntry[0], 60);
      applyStimulus(4'b1111, 0, 0, 2'b00, 2'b00, 6'd0, 0);
      checkOutput("after_mix_gnt", dspGnt, 4'b0011);

      // Fill the FIFO under stall, then drain in release order.
      applyStimulus(4'b0000, 1, 0, 2'b11, 2'b11, 6'd10, 0);
      checkOutput("fill0_rel_rdy", relRdy, 1);
      applyStimulus(4'b0000, 1, 0, 2'b11, 2'b11, 6'd20, 0);
      checkOutput("fill4_rel_rdy", relRdy, 1);
      checkOutput("fill4_ret_vld", retVld, 4'b0000);
      applyStimulus(4'b0000, 1, 0, 2'b11, 2'b11, 6'd30, 0);
      checkOutput("fill8_rel_rdy", relRdy, 0);
      checkOutput("fill8_ret_vld", retVld, 4'b0000);
      applyStimulus(4'b0000, 0, 0, 2'b00, 2'b00, 6'd0, 0);
      checkOutput("unstall_ret_vld", retVld, 4'b1111);
      checkOutput("unstall_entry0", retEntry[0], 10);
      checkOutput("unstall_entry2", retEntry[2], 12);
      checkOutput("unstall_entry3", retEntry[3], 13);
      applyStimulus(4'b0000, 0, 0, 2'b00, 2'b00, 6'd0, 0);
      checkOutput("second_drain_entry3", retEntry[3], 23);
      checkOutput("second_drain_rdy", relRdy, 1);
      applyStimulus(4'b0000, 0, 0, 2'b00, 2'b00, 6'd0, 0);

      // Credit 10, FIFO holds 5, then a one-cycle flush pulse.
      applyStimulus(4'b0000, 0, 0, 2'b11, 2'b00, 6'd40, 0);
      applyStimulus(4'b0000, 0, 0, 2'b00, 2'b00, 6'd0, 0);
      applyStimulus(4'b0000, 1, 0, 2'b11, 2'b11, 6'd0, 0);
      applyStimulus(4'b0000, 1, 0, 2'b01, 2'b00, 6'd4, 0);
      applyStimulus(4'b1111, 1, 1, 2'b00, 2'b00, 6'd0, 0);
      checkOutput("pulse_rel_rdy", relRdy, 0);
      checkOutput("pulse_fmgr_stall", fmgrStall, 0);
      checkOutput("pulse_gnt", dspGnt, 4'b0000);
      checkOutput("pulse_ret_vld", retVld, 4'b0000);
      applyStimulus(4'b1111, 0, 0, 2'b00, 2'b00, 6'd0, 0);
      checkOutput("flush_busy", dspBusy, 1);
      checkOutput("flush_gnt", dspGnt, 4'b0000);
      applyStimulus(4'b1111, 0, 0, 2'b00, 2'b00, 6'd0, 0);
      checkOutput("recover_busy", dspBusy, 0);
      checkOutput("recover_gnt", dspGnt, 4'b1111);
      checkOutput("recover_ret_vld", retVld, 4'b0000);
      checkOutput("recover_rel_rdy", relRdy, 1);

      // Free list reports empty during a one-slot grant; error is sticky.
      applyStimulus(4'b0001, 0, 0, 2'b00, 2'b00, 6'd0, 1);
      checkOutput("empty_gnt", dspGnt, 4'b0001);
      checkOutput("empty_err_before", errOut, 0);
      applyStimulus(4'b0000, 0, 0, 2'b00, 2'b00, 6'd0, 0);
      checkOutput("err_set", errOut, 1);
      applyStimulus(4'b0000, 0, 1, 2'b00, 2'b00, 6'd0, 0);
      applyStimulus(4'b0000, 0, 1, 2'b00, 2'b00, 6'd0, 0);
      checkOutput("long_flush_busy", dspBusy, 1);
      applyStimulus(4'b0000, 0, 0, 2'b00, 2'b00, 6'd0, 0);
      checkOutput("tail_flush_busy", dspBusy, 1);
      applyStimulus(4'b0000, 0, 0, 2'b00, 2'b00, 6'd0, 0);
      checkOutput("err_after_flush", errOut, 1);
      checkOutput("post_flush_busy", dspBusy, 0);
      applyStimulus(4'b0000, 0, 0, 2'b00, 2'b00, 6'd0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
